div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 33 +++
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg : shared encodings and helpers for the iterative divider
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg  = 5'd0;

  // Two's-complement negate when the flag is set.
  function automatic logic [31:0] neg_if(input logic i_neg, input logic [31:0] i_val);
    return i_neg ? (~i_val + 32'd1) : i_val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : multi-cycle restoring radix-2 divider with register-file write
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  waddr_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);

  localparam logic [5:0] C_ITER = 6'(DIV_ITER);

  div_state_e  r_state;
  div_op_e     r_op;
  logic [4:0]  r_waddr;
  logic [31:0] r_div;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_busy;
  logic        r_we;
  logic [4:0]  r_wa_out;
  logic [31:0] r_wd_out;

  div_op_e     w_op;
  logic        w_signed;
  logic        w_is_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic [31:0] w_special;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_calc_res;

  // Operand decode for the request currently presented by EX
  always_comb begin
    w_op       = div_op_e'(op_i);
    w_signed   = (w_op == OP_DIV) || (w_op == OP_REM);
    w_is_div   = (w_op == OP_DIV) || (w_op == OP_DIVU);
    w_a_neg    = w_signed & dividend_i[31];
    w_b_neg    = w_signed & divisor_i[31];
    w_a_mag    = neg_if(w_a_neg, dividend_i);
    w_b_mag    = neg_if(w_b_neg, divisor_i);
    w_div_zero = (divisor_i == ZeroWord);
    w_ovf      = w_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    if (w_div_zero) begin
      w_special = w_is_div ? 32'hFFFF_FFFF : dividend_i;
    end else begin
      w_special = w_is_div ? 32'h8000_0000 : ZeroWord;
    end
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits
  always_comb begin
    w_trial  = {r_rem, r_quo[31]};
    w_diff   = w_trial - {1'b0, r_div};
    w_ge     = ~w_diff[32];
    w_rem_nx = w_ge ? w_diff[31:0] : w_trial[31:0];
    w_quo_nx = {r_quo[30:0], w_ge};
    if ((r_op == OP_DIV) || (r_op == OP_DIVU)) begin
      w_calc_res = neg_if(r_q_neg, w_quo_nx);
    end else begin
      w_calc_res = neg_if(r_r_neg, w_rem_nx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_DIV;
      r_waddr  <= ZeroReg;
      r_div    <= ZeroWord;
      r_quo    <= ZeroWord;
      r_rem    <= ZeroWord;
      r_cnt    <= 6'd0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_busy   <= 1'b0;
      r_we     <= 1'b0;
      r_wa_out <= ZeroReg;
      r_wd_out <= ZeroWord;
    end else begin
      r_we     <= 1'b0;
      r_wa_out <= ZeroReg;
      r_wd_out <= ZeroWord;
      if (kill_i) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 6'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_op    <= w_op;
              r_waddr <= waddr_i;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_busy  <= 1'b1;
              if (w_div_zero || w_ovf) begin
                r_state  <= ST_DONE;
                r_we     <= (waddr_i != ZeroReg);
                r_wa_out <= waddr_i;
                r_wd_out <= w_special;
              end else begin
                r_state <= ST_CALC;
                r_cnt   <= C_ITER;
                r_quo   <= w_a_mag;
                r_div   <= w_b_mag;
                r_rem   <= ZeroWord;
              end
            end
          end
          ST_CALC: begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            if (r_cnt != 6'd0) begin
              r_cnt <= r_cnt - 6'd1;
            end
            // The final step's result is captured directly into the write port
            if (r_cnt < 6'd2) begin
              r_state  <= ST_DONE;
              r_we     <= (r_waddr != ZeroReg);
              r_wa_out <= r_waddr;
              r_wd_out <= w_calc_res;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A flush arriving during the write cycle still suppresses the write
  assign reg_we_o    = r_we & ~kill_i;
  assign reg_waddr_o = r_wa_out;
  assign reg_wdata_o = r_wd_out;
  assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : directed self-checking bench for div_unit
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_div_unit;

  localparam logic [1:0] C_DIV  = 2'b00;
  localparam logic [1:0] C_DIVU = 2'b01;
  localparam logic [1:0] C_REM  = 2'b10;
  localparam logic [1:0] C_REMU = 2'b11;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  waddr_i;
  logic        kill_i;
  logic        busy_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int          n_checks;
  int          n_fail;
  int          n_we;
  int          we_lat;
  logic [31:0] got_wd;
  logic [4:0]  got_wa;
  logic        done_ok;
  int          stray_we;

  div_unit #(.DIV_ITER(32)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .waddr_i     (waddr_i),
    .kill_i      (kill_i),
    .busy_o      (busy_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the start cycle is the one that follows.
  // With i_poke, a stray start is raised mid-CALC and must be ignored.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input bit i_poke);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    waddr_i    = wa;
    n_we       = 0;
    we_lat     = 0;
    got_wd     = 32'h0;
    got_wa     = 5'd0;
    done_ok    = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start_i = i_poke && (cyc == 5);
      if (i_poke && cyc == 5) begin
        op_i       = C_DIVU;
        dividend_i = 32'd999;
        divisor_i  = 32'd1;
        waddr_i    = 5'd9;
      end
      if (reg_we_o) begin
        n_we++;
        if (n_we == 1) begin
          we_lat = cyc;
          got_wd = reg_wdata_o;
          got_wa = reg_waddr_o;
        end
      end
      if (!busy_o) begin
        done_ok = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    chk("op_terminates", {31'd0, done_ok}, 32'd1);
  endtask

  task automatic op_expect(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wa,
                           input logic [31:0] exp, input int exp_lat);
    do_op(op, a, b, wa, 1'b0);
    chk({tag, "_data"}, got_wd, exp);
    chk({tag, "_lat"}, 32'(we_lat), 32'(exp_lat));
    chk({tag, "_nwe"}, 32'(n_we), 32'd1);
    chk({tag, "_waddr"}, {27'd0, got_wa}, {27'd0, wa});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    stray_we   = 0;
    rst        = 1'b1;
    start_i    = 1'b0;
    op_i       = 2'b00;
    dividend_i = 32'h0;
    divisor_i  = 32'h0;
    waddr_i    = 5'd0;
    kill_i     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_we",    {31'd0, reg_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op_expect("divu_100_7", C_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    op_expect("remu_100_7", C_REMU, 32'd100, 32'd7, 5'd3, 32'd2, 33);
    op_expect("div_m7_2",   C_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    op_expect("rem_m7_2",   C_REM,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
    op_expect("div_100_m7", C_DIV,  32'd100, 32'hFFFF_FFF9, 5'd6, 32'hFFFF_FFF2, 33);
    op_expect("rem_m100_7", C_REM,  32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 33);
    op_expect("divu_max_1", C_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33);
    op_expect("divu_x_0",   C_DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    op_expect("rem_x_0",    C_REM,  32'd5, 32'd0, 5'd7, 32'd5, 1);
    op_expect("div_ovf",    C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
    op_expect("rem_ovf",    C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1);

    // Destination x0: no write, but the unit must still release the pipeline
    do_op(C_DIVU, 32'd100, 32'd7, 5'd0, 1'b0);
    chk("x0_nwe", 32'(n_we), 32'd0);

    // Stray start during CALC is ignored
    do_op(C_DIVU, 32'd100, 32'd7, 5'd4, 1'b1);
    chk("poke_nwe",  32'(n_we), 32'd1);
    chk("poke_data", got_wd, 32'd14);
    chk("poke_lat",  32'(we_lat), 32'd33);

    // Kill at cycle 10, restart at cycle 12
    start_i    = 1'b1;
    op_i       = C_DIVU;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    waddr_i    = 5'd10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      kill_i  = (c == 10);
      if (reg_we_o) stray_we++;
      if (c == 11) chk("kill_busy", {31'd0, busy_o}, 32'd0);
    end
    chk("kill_nwe", 32'(stray_we), 32'd0);
    op_expect("after_kill", C_REMU, 32'd100, 32'd7, 5'd11, 32'd2, 33);

    // Asynchronous reset mid-operation, then an immediate new start
    stray_we   = 0;
    start_i    = 1'b1;
    op_i       = C_DIVU;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    waddr_i    = 5'd12;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (reg_we_o) stray_we++;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    if (reg_we_o) stray_we++;
    rst = 1'b0;
    op_expect("after_rst", C_DIVU, 32'd1000, 32'd3, 5'd13, 32'd333, 33);
    chk("rst_mid_nwe", 32'(stray_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
